softmax_sampler: RTL and testbench

SOFTMAX_SAMPLER -- requirements
Module: softmax_sampler

---
 rtl/softmax_sampler_if.sv | 26 ++
 rtl/softmax_sampler.sv | 135 +++++++++++++
 tb/tb_softmax_sampler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/softmax_sampler_if.sv
// Handshake bundle for softmax_sampler: probability vector in, sampled index out.
interface softmax_sampler_if #(
    parameter int LEN = 8
) ();
    localparam int IW = $clog2(LEN);
    localparam int SW = 16 + IW;

    logic                  valid_in;
    logic                  ready_in;
    logic [LEN-1:0][15:0]  probs;
    logic                  valid_out;
    logic                  ready_out;
    logic [IW-1:0]         sample_idx;
    logic [SW-1:0]         thr_out;
    logic                  zero_err;

    modport master (
        output valid_in, probs, ready_out,
        input  ready_in, valid_out, sample_idx, thr_out, zero_err
    );

    modport slave (
        input  valid_in, probs, ready_out,
        output ready_in, valid_out, sample_idx, thr_out, zero_err
    );
endinterface

// File: rtl/softmax_sampler.sv
// Draws one index from an unnormalised Q0.16 probability vector using an LFSR
// threshold scaled by the vector sum, then a fixed-length cumulative scan.
module softmax_sampler #(
    parameter int          LEN  = 8,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    softmax_sampler_if.slave   bus
);
    localparam int IW = $clog2(LEN);
    localparam int SW = 16 + IW;

    typedef enum logic [2:0] {IDLE, SUM, SCALE, SCAN, OUT} state_t;

    state_t               state_q;
    logic [15:0]          lfsr_q;
    logic [15:0]          r_q;
    logic [LEN-1:0][15:0] probs_q;
    logic [IW-1:0]        cnt_q;
    logic [SW-1:0]        s_q;
    logic [SW-1:0]        t_q;
    logic [SW-1:0]        c_q;
    logic                 found_q;
    logic [IW-1:0]        idx_q;
    logic                 ready_in_q;
    logic                 valid_out_q;
    logic [IW-1:0]        sample_idx_q;
    logic [SW-1:0]        thr_q;
    logic                 zero_err_q;

    logic [15:0]          lfsr_d;
    logic [16+SW-1:0]     prod_d;
    logic [SW-1:0]        c_d;
    logic                 hit_d;
    logic                 last_d;
    logic [IW-1:0]        sel_d;

    // Galois form shifting right: feedback taps are applied when bit 0 falls out.
    assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign prod_d = {{SW{1'b0}}, r_q} * {16'h0000, s_q};
    assign c_d    = c_q + SW'(probs_q[cnt_q]);
    assign hit_d  = !found_q && (c_d > t_q);
    assign last_d = (cnt_q == IW'(LEN - 1));

    // A zero-sum vector never crosses the threshold, so it must be forced to 0.
    always_comb begin
        sel_d = IW'(LEN - 1);
        if (s_q == '0)
            sel_d = '0;
        else if (found_q)
            sel_d = idx_q;
        else if (hit_d)
            sel_d = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED;
            r_q          <= '0;
            probs_q      <= '0;
            cnt_q        <= '0;
            s_q          <= '0;
            t_q          <= '0;
            c_q          <= '0;
            found_q      <= 1'b0;
            idx_q        <= '0;
            ready_in_q   <= 1'b1;
            valid_out_q  <= 1'b0;
            sample_idx_q <= '0;
            thr_q        <= '0;
            zero_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_in) begin
                        probs_q    <= bus.probs;
                        r_q        <= lfsr_q;
                        lfsr_q     <= lfsr_d;
                        s_q        <= '0;
                        cnt_q      <= '0;
                        ready_in_q <= 1'b0;
                        state_q    <= SUM;
                    end
                end
                SUM: begin
                    s_q   <= s_q + SW'(probs_q[cnt_q]);
                    cnt_q <= cnt_q + IW'(1);
                    if (last_d) begin
                        cnt_q   <= '0;
                        state_q <= SCALE;
                    end
                end
                SCALE: begin
                    t_q     <= prod_d[16+SW-1:16];
                    c_q     <= '0;
                    found_q <= 1'b0;
                    idx_q   <= '0;
                    state_q <= SCAN;
                end
                SCAN: begin
                    c_q   <= c_d;
                    cnt_q <= cnt_q + IW'(1);
                    if (hit_d) begin
                        found_q <= 1'b1;
                        idx_q   <= cnt_q;
                    end
                    if (last_d) begin
                        cnt_q        <= '0;
                        sample_idx_q <= sel_d;
                        thr_q        <= t_q;
                        zero_err_q   <= (s_q == '0);
                        valid_out_q  <= 1'b1;
                        state_q      <= OUT;
                    end
                end
                OUT: begin
                    if (bus.ready_out) begin
                        valid_out_q <= 1'b0;
                        ready_in_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready_in   = ready_in_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.sample_idx = sample_idx_q;
    assign bus.thr_out    = thr_q;
    assign bus.zero_err   = zero_err_q;
endmodule

// File: tb/tb_softmax_sampler.sv
// Scoreboard bench for softmax_sampler: an independent LFSR/sum/scan model predicts
// every result, directed cases cover one-hot, uniform, zero, backpressure and reset.
module tb_softmax_sampler;
    localparam int          LEN  = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef logic [LEN-1:0][15:0] vec_t;
    typedef struct {
        int     idx;
        longint thr;
        int     zerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    softmax_sampler_if #(.LEN(LEN)) bus ();

    softmax_sampler #(.LEN(LEN), .SEED(SEED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        expQ[$];
    logic [15:0] tbLfsr;
    int          obsIdx;
    longint      obsThr;
    int          obsZerr;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] lfsrStep(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic exp_t model(input vec_t p, input logic [15:0] r);
        longint s = 0;
        longint c = 0;
        longint t;
        exp_t   e;
        e.idx = -1;
        for (int i = 0; i < LEN; i++) s += longint'(p[i]);
        t = (longint'(r) * s) >> 16;
        for (int i = 0; i < LEN; i++) begin
            c += longint'(p[i]);
            if (e.idx < 0 && c > t) e.idx = i;
        end
        if (s == 0) begin
            e.idx  = 0;
            e.zerr = 1;
        end else begin
            e.zerr = 0;
            if (e.idx < 0) e.idx = LEN - 1;
        end
        e.thr = t;
        return e;
    endfunction

    function automatic vec_t randomVec();
        vec_t v;
        int   mode;
        mode = $urandom_range(0, 9);
        for (int i = 0; i < LEN; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i] = 16'h0000;
                1:       v[i] = 16'($urandom_range(1, 255));
                default: v[i] = 16'($urandom_range(0, 65535));
            endcase
            if (mode == 0) v[i] = 16'h0000;
        end
        return v;
    endfunction

    task automatic doReset();
        rst           = 1'b1;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b0;
        bus.probs     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tbLfsr = SEED;
        expQ.delete();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t p);
        int n;
        n = 0;
        while (!bus.ready_in && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready_in) checkOutput("ready_in_timeout", 0, 1);
        bus.valid_in = 1'b1;
        bus.probs    = p;
        expQ.push_back(model(p, tbLfsr));
        tbLfsr = lfsrStep(tbLfsr);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.probs    = randomVec();
    endtask

    task automatic runVector(input vec_t p, input int hold);
        int   lat;
        exp_t e;
        applyStimulus(p);
        lat = 0;
        while (lat < 4 * LEN + 10) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.valid_out) break;
            bus.valid_in  = 1'($urandom_range(0, 1));
            bus.probs     = randomVec();
            bus.ready_out = 1'($urandom_range(0, 1));
        end
        bus.valid_in  = 1'b0;
        bus.ready_out = (hold == 0);
        checkOutput("latency", lat, 2 * LEN + 1);
        e = expQ.pop_front();
        if (!bus.valid_out) return;
        obsIdx  = int'(bus.sample_idx);
        obsThr  = longint'(bus.thr_out);
        obsZerr = int'(bus.zero_err);
        checkOutput("sample_idx", obsIdx, e.idx);
        checkOutput("thr_out", obsThr, e.thr);
        checkOutput("zero_err", obsZerr, e.zerr);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid_out", bus.valid_out, 1);
            checkOutput("hold_sample_idx", bus.sample_idx, e.idx);
            checkOutput("hold_thr_out", bus.thr_out, e.thr);
            checkOutput("hold_ready_in", bus.ready_in, 0);
        end
        bus.ready_out = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_out = 1'b0;
        checkOutput("post_hs_valid_out", bus.valid_out, 0);
        checkOutput("post_hs_ready_in", bus.ready_in, 1);
    endtask

    initial begin
        vec_t v;
        int   seen;

        doReset();
        checkOutput("reset_ready_in", bus.ready_in, 1);
        checkOutput("reset_valid_out", bus.valid_out, 0);
        checkOutput("reset_sample_idx", bus.sample_idx, 0);
        checkOutput("reset_thr_out", bus.thr_out, 0);
        checkOutput("reset_zero_err", bus.zero_err, 0);

        $display("[TB] one-hot vector");
        v    = '0;
        v[5] = 16'hFFFF;
        runVector(v, 0);
        checkOutput("onehot_idx_const", obsIdx, 5);
        checkOutput("onehot_zerr_const", obsZerr, 0);

        $display("[TB] uniform vector with backpressure");
        doReset();
        for (int i = 0; i < LEN; i++) v[i] = 16'd8192;
        runVector(v, 5);
        checkOutput("uniform_thr_const", obsThr, 44257);
        checkOutput("uniform_idx_const", obsIdx, 5);

        $display("[TB] zero vector");
        v = '0;
        runVector(v, 0);
        checkOutput("zero_idx_const", obsIdx, 0);
        checkOutput("zero_zerr_const", obsZerr, 1);
        checkOutput("zero_thr_const", obsThr, 0);

        $display("[TB] reset during scan");
        for (int i = 0; i < LEN; i++) v[i] = 16'd8192;
        applyStimulus(v);
        void'(expQ.pop_back());
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        #10 rst = 1'b0;
        tbLfsr = SEED;
        seen   = 0;
        repeat (2 * LEN + 5) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) seen++;
        end
        checkOutput("no_valid_after_rst", seen, 0);
        checkOutput("ready_in_after_rst", bus.ready_in, 1);
        runVector(v, 0);
        checkOutput("rst_reuse_seed_thr", obsThr, 44257);

        $display("[TB] random regression");
        for (int n = 0; n < 1000; n++) runVector(randomVec(), (n % 50 == 0) ? 2 : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
